// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing NUM_REGS multi-byte write registers and read-back ports
module i2c_target_regfile #(
  parameter int NUM_REGS   = 4,
  parameter int DATA_BYTES = 2,
  localparam int DATA_W    = 8 * DATA_BYTES
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       SCL,
  input  logic                       SDA_OUT,
  output logic                       SDA_IN,
  input  logic [6:0]                 I2CS_ADDR,
  input  logic [NUM_REGS*DATA_W-1:0] RD_DATA,
  output logic [NUM_REGS*DATA_W-1:0] WR_DATA,
  output logic [NUM_REGS-1:0]        WR_STROBE,
  output logic                       BUSY
);

  localparam int PTR_W = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
  } state_t;

  state_t state_q, state_d;

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]                 bit_cnt_q, bit_cnt_d;
  logic [2:0]                 byte_cnt_q, byte_cnt_d;
  logic [6:0]                 shift_q, shift_d;
  logic                       rw_q, rw_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d, ptr_inc;
  logic [DATA_W-1:0]          shadow_q, shadow_d, shadow_n;
  logic [DATA_W-1:0]          rd_buf_q, rd_buf_d, rd_sel, tx_word;
  logic [NUM_REGS*DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]        strobe_q, strobe_d;
  logic                       sda_drv_q, sda_drv_d;
  logic                       busy_q, busy_d;
  logic                       ack_on_q, ack_on_d;
  logic                       mack_q, mack_d;
  logic [7:0]                 byte_in;

  // Bus SDA is the wired-AND of both drivers, so our own drive is seen too.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      scl_s <= 1'b1;
      scl_p <= 1'b1;
      sda_s <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_s <= SCL;
      scl_p <= scl_s;
      sda_s <= SDA_OUT & SDA_IN;
      sda_p <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  assign byte_in  = {shift_q, sda_s};
  assign ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
  assign shadow_n = (shadow_q << 8) | DATA_W'(byte_in);
  // First byte of a register comes straight from RD_DATA, later bytes from the capture.
  assign tx_word  = (byte_cnt_q == 3'd0) ? rd_sel : rd_buf_q;

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ptr_q == PTR_W'(k)) rd_sel = RD_DATA[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    ptr_d      = ptr_q;
    shadow_d   = shadow_q;
    rd_buf_d   = rd_buf_q;
    wr_data_d  = wr_data_q;
    strobe_d   = '0;
    sda_drv_d  = sda_drv_q;
    busy_d     = busy_q;
    ack_on_d   = ack_on_q;
    mack_d     = mack_q;

    if (stop_det) begin
      state_d    = IDLE;
      sda_drv_d  = 1'b1;
      busy_d     = 1'b0;
      ack_on_d   = 1'b0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      shadow_d   = '0;
    end else if (start_det) begin
      state_d    = ADDR;
      sda_drv_d  = 1'b1;
      ack_on_d   = 1'b0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      shadow_d   = '0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              rw_d      = byte_in[0];
              if (byte_in[7:1] == I2CS_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        // ACK phases: pull low on the first falling edge, leave on the second.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_drv_d = 1'b0;
              ack_on_d  = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              bit_cnt_d = '0;
              if (rw_q) begin
                state_d   = RD;
                rd_buf_d  = tx_word;
                sda_drv_d = tx_word[DATA_W-1];
              end else begin
                state_d   = PTR;
                sda_drv_d = 1'b1;
              end
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (byte_in < 8'(NUM_REGS)) begin
                ptr_d   = byte_in[PTR_W-1:0];
                state_d = PTR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_drv_d = 1'b0;
              ack_on_d  = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              sda_drv_d = 1'b1;
              bit_cnt_d = '0;
              state_d   = WR;
            end
          end
        end
        WR: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = WR_ACK;
              if (byte_cnt_q + 3'd1 == 3'(DATA_BYTES)) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                  if (ptr_q == PTR_W'(k)) begin
                    wr_data_d[k*DATA_W +: DATA_W] = shadow_n;
                    strobe_d[k]                   = 1'b1;
                  end
                end
                ptr_d      = ptr_inc;
                byte_cnt_d = '0;
                shadow_d   = '0;
              end else begin
                shadow_d   = shadow_n;
                byte_cnt_d = byte_cnt_q + 3'd1;
              end
            end
          end
        end
        RD: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
          if (scl_fall) begin
            rd_buf_d = rd_buf_q << 1;
            if (bit_cnt_q == 4'd8) begin
              sda_drv_d  = 1'b1;
              bit_cnt_d  = '0;
              byte_cnt_d = byte_cnt_q + 3'd1;
              state_d    = RD_ACK;
            end else begin
              sda_drv_d = rd_buf_q[DATA_W-2];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            ack_on_d = 1'b1;
            mack_d   = ~sda_s;
            // The pointer advances on a finished register whether or not the controller ACKs.
            if (byte_cnt_q == 3'(DATA_BYTES)) begin
              ptr_d      = ptr_inc;
              byte_cnt_d = '0;
            end
          end else if (scl_fall && ack_on_q) begin
            ack_on_d = 1'b0;
            if (mack_q) begin
              state_d   = RD;
              bit_cnt_d = '0;
              rd_buf_d  = tx_word;
              sda_drv_d = tx_word[DATA_W-1];
            end else begin
              state_d   = IGNORE;
              sda_drv_d = 1'b1;
            end
          end
        end
        IGNORE: sda_drv_d = 1'b1;
        default: begin
          state_d   = IDLE;
          sda_drv_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      ptr_q      <= '0;
      shadow_q   <= '0;
      rd_buf_q   <= '0;
      wr_data_q  <= '0;
      strobe_q   <= '0;
      sda_drv_q  <= 1'b1;
      busy_q     <= 1'b0;
      ack_on_q   <= 1'b0;
      mack_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      ptr_q      <= ptr_d;
      shadow_q   <= shadow_d;
      rd_buf_q   <= rd_buf_d;
      wr_data_q  <= wr_data_d;
      strobe_q   <= strobe_d;
      sda_drv_q  <= sda_drv_d;
      busy_q     <= busy_d;
      ack_on_q   <= ack_on_d;
      mack_q     <= mack_d;
    end
  end

  assign SDA_IN    = sda_drv_q;
  assign WR_DATA   = wr_data_q;
  assign WR_STROBE = strobe_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - directed bench for i2c_target_regfile
module tb_i2c_target_regfile;

  localparam int Q = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        SCL = 1'b1;
  logic        SDA_OUT = 1'b1;
  logic        SDA_IN;
  logic [6:0]  I2CS_ADDR = 7'h2A;
  logic [63:0] RD_DATA = {16'h7E81, 16'h2468, 16'h1357, 16'hA5C3};
  logic [63:0] WR_DATA;
  logic [3:0]  WR_STROBE;
  logic        BUSY;

  int n_cmp = 0;
  int n_fail = 0;
  logic [3:0] slog[$];
  int sda_low_cnt = 0;

  i2c_target_regfile #(.NUM_REGS(4), .DATA_BYTES(2)) dut (
    .CLK(CLK), .RESET(RESET), .SCL(SCL), .SDA_OUT(SDA_OUT), .SDA_IN(SDA_IN),
    .I2CS_ADDR(I2CS_ADDR), .RD_DATA(RD_DATA), .WR_DATA(WR_DATA),
    .WR_STROBE(WR_STROBE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WR_STROBE != 4'd0) slog.push_back(WR_STROBE);
    if (!SDA_IN) sda_low_cnt++;
  end

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  ptr;
    int          n;
    logic [31:0] data;
    logic [5:0]  exp_acks;
    int          exp_nstrobe;
    logic [7:0]  exp_strobes;
    logic [63:0] exp_wr;
  } wvec_t;

  wvec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_q(input int n = 1);
    repeat (n * Q) @(negedge CLK);
  endtask

  task automatic write_bit(input logic b);
    SDA_OUT = b; wait_q(); SCL = 1'b1; wait_q(2); SCL = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    SDA_OUT = 1'b1; wait_q(); SCL = 1'b1; wait_q();
    b = SDA_OUT & SDA_IN;
    wait_q(); SCL = 1'b0; wait_q();
  endtask

  task automatic i2c_start();
    SDA_OUT = 1'b1; wait_q(); SCL = 1'b1; wait_q(); SDA_OUT = 1'b0; wait_q(); SCL = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    SDA_OUT = 1'b0; wait_q(); SCL = 1'b1; wait_q(); SDA_OUT = 1'b1; wait_q(2);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int b = 7; b >= 0; b--) write_bit(v[b]);
    read_bit(ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] v);
    logic bv;
    for (int b = 7; b >= 0; b--) begin
      read_bit(bv);
      v[b] = bv;
    end
    write_bit(mack);
  endtask

  task automatic wr_txn(input logic [7:0] a, input logic [7:0] p, input int n,
                        input logic [31:0] d, output logic [5:0] acks);
    logic ak;
    acks = '1;
    i2c_start();
    send_byte(a, ak); acks[0] = ak;
    send_byte(p, ak); acks[1] = ak;
    for (int i = 0; i < n; i++) begin
      send_byte(d[31-8*i -: 8], ak);
      acks[2+i] = ak;
    end
    i2c_stop();
  endtask

  initial begin
    logic [5:0] acks;
    logic       ak;
    logic [7:0] rb;
    int         base;
    int         low0;

    vecs[0] = '{8'h54, 8'h01, 2, 32'hBEEF_0000, 6'b110000, 1, 8'h02, 64'h0000_0000_BEEF_0000};
    vecs[1] = '{8'h54, 8'h03, 4, 32'h1122_3344, 6'b000000, 2, 8'h18, 64'h1122_0000_BEEF_3344};
    vecs[2] = '{8'h56, 8'h00, 2, 32'h9988_0000, 6'b111111, 0, 8'h00, 64'h1122_0000_BEEF_3344};
    vecs[3] = '{8'h54, 8'h07, 2, 32'h7766_0000, 6'b111110, 0, 8'h00, 64'h1122_0000_BEEF_3344};
    vecs[4] = '{8'h54, 8'h02, 1, 32'h5A00_0000, 6'b111000, 0, 8'h00, 64'h1122_0000_BEEF_3344};
    vecs[5] = '{8'h54, 8'h02, 2, 32'h5A6B_0000, 6'b110000, 1, 8'h04, 64'h1122_5A6B_BEEF_3344};
    vecs[6] = '{8'h54, 8'h04, 2, 32'hDDCC_0000, 6'b111110, 0, 8'h00, 64'h1122_5A6B_BEEF_3344};
    vecs[7] = '{8'h54, 8'h01, 3, 32'hCAFE_1200, 6'b100000, 1, 8'h02, 64'h1122_5A6B_CAFE_3344};

    RESET = 1'b0;
    repeat (4) @(negedge CLK);
    check("reset sda_in", 64'(SDA_IN), 64'd1);
    check("reset wr_data", WR_DATA, 64'd0);
    check("reset strobe", 64'(WR_STROBE), 64'd0);
    check("reset busy", 64'(BUSY), 64'd0);
    RESET = 1'b1;
    wait_q(2);

    for (int i = 0; i < 8; i++) begin
      base = slog.size();
      low0 = sda_low_cnt;
      wr_txn(vecs[i].addr, vecs[i].ptr, vecs[i].n, vecs[i].data, acks);
      check($sformatf("v%0d acks", i), 64'(acks), 64'(vecs[i].exp_acks));
      check($sformatf("v%0d strobe count", i), 64'(slog.size() - base), 64'(vecs[i].exp_nstrobe));
      if (vecs[i].exp_nstrobe > 0 && slog.size() > base)
        check($sformatf("v%0d strobe0", i), 64'(slog[base]), 64'(vecs[i].exp_strobes[3:0]));
      if (vecs[i].exp_nstrobe > 1 && slog.size() > base + 1)
        check($sformatf("v%0d strobe1", i), 64'(slog[base+1]), 64'(vecs[i].exp_strobes[7:4]));
      check($sformatf("v%0d wr_data", i), WR_DATA, vecs[i].exp_wr);
      check($sformatf("v%0d busy after stop", i), 64'(BUSY), 64'd0);
      if (vecs[i].exp_acks == 6'h3f)
        check($sformatf("v%0d sda never low", i), 64'(sda_low_cnt - low0), 64'd0);
    end

    // Pointer write, repeated START, two-byte read of reg0 then NACK.
    base = slog.size();
    i2c_start();
    send_byte(8'h54, ak); check("r1 addr ack", 64'(ak), 64'd0);
    send_byte(8'h00, ak); check("r1 ptr ack", 64'(ak), 64'd0);
    i2c_start();
    send_byte(8'h55, ak); check("r1 read addr ack", 64'(ak), 64'd0);
    check("r1 busy", 64'(BUSY), 64'd1);
    recv_byte(1'b0, rb); check("r1 byte0", 64'(rb), 64'hA5);
    recv_byte(1'b1, rb); check("r1 byte1", 64'(rb), 64'hC3);
    i2c_stop();
    check("r1 busy after stop", 64'(BUSY), 64'd0);

    // Pointer must now be 1.
    i2c_start();
    send_byte(8'h55, ak); check("r2 addr ack", 64'(ak), 64'd0);
    recv_byte(1'b1, rb); check("r2 byte0 reg1", 64'(rb), 64'h13);
    i2c_stop();

    // Read from reg3 across the wrap to reg0.
    i2c_start();
    send_byte(8'h54, ak);
    send_byte(8'h03, ak); check("r3 ptr ack", 64'(ak), 64'd0);
    i2c_start();
    send_byte(8'h55, ak); check("r3 read addr ack", 64'(ak), 64'd0);
    recv_byte(1'b0, rb); check("r3 byte0", 64'(rb), 64'h7E);
    recv_byte(1'b0, rb); check("r3 byte1", 64'(rb), 64'h81);
    recv_byte(1'b1, rb); check("r3 byte2 wrap", 64'(rb), 64'hA5);
    i2c_stop();
    i2c_start();
    send_byte(8'h55, ak);
    recv_byte(1'b1, rb); check("r4 byte0 reg0", 64'(rb), 64'hA5);
    i2c_stop();
    check("reads no strobe", 64'(slog.size() - base), 64'd0);

    // Reset in the middle of a write.
    base = slog.size();
    i2c_start();
    send_byte(8'h54, ak);
    send_byte(8'h00, ak);
    send_byte(8'hDE, ak); check("rst data ack", 64'(ak), 64'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst wr_data", WR_DATA, 64'd0);
    check("rst sda_in", 64'(SDA_IN), 64'd1);
    check("rst busy", 64'(BUSY), 64'd0);
    RESET = 1'b1;
    i2c_stop();
    check("rst no strobe", 64'(slog.size() - base), 64'd0);
    wr_txn(8'h54, 8'h00, 2, 32'h1234_0000, acks);
    check("post rst acks", 64'(acks), 64'(6'b110000));
    check("post rst wr_data", WR_DATA, 64'h0000_0000_0000_1234);
    check("post rst strobe count", 64'(slog.size() - base), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
